// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty levels and sticky error flags.
// Define SYNC_FIFO_PROG_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo_prog #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  input  logic             clr_err,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned    DEPTH    = 1 << ASIZE;
  localparam logic [ASIZE:0] FULL_CNT = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_CNT   = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_CNT   = (ASIZE+1)'(AE_LEVEL);
  localparam logic [ASIZE:0] PTR_ONE  = (ASIZE+1)'(1);

  logic [DSIZE-1:0] mem_q [DEPTH];

  logic [ASIZE:0]   wptr_q, wptr_d;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic [ASIZE:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_en, rd_en;
  logic             full_int, empty_int;
  logic [ASIZE-1:0] waddr, raddr;

  // Status flags come only from the registered occupancy.
  assign full_int      = (count_q == FULL_CNT);
  assign empty_int     = (count_q == '0);
  assign wfull         = full_int;
  assign rempty        = empty_int;
  assign walmost_full  = (count_q >= AF_CNT);
  assign ralmost_empty = (count_q <= AE_CNT);
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;
  assign waddr         = wptr_q[ASIZE-1:0];
  assign raddr         = rptr_q[ASIZE-1:0];

  always_comb begin
    wr_en  = winc && !full_int;
    rd_en  = rinc && !empty_int;
    wptr_d = wr_en ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d = rd_en ? (rptr_q + PTR_ONE) : rptr_q;
    // Pointer difference over ASIZE+1 bits is the occupancy, wrap included.
    count_d     = wptr_d - rptr_d;
    overflow_d  = (overflow_q  && !clr_err) || (winc && full_int);
    underflow_d = (underflow_q && !clr_err) || (rinc && empty_int);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[waddr] <= wdata;
    end
  end

`ifdef SYNC_FIFO_PROG_FWFT_EN
  assign rdata = empty_int ? '0 : mem_q[raddr];
`else
  logic [DSIZE-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rd_en ? mem_q[raddr] : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Randomised self-checking bench for sync_fifo_prog against a queue-based occupancy model.
module tb_sync_fifo_prog;
  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic             clk;
  logic             rst;
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             wfull;
  logic             walmost_full;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             ralmost_empty;
  logic [ASIZE:0]   count;
  logic             clr_err;
  logic             overflow;
  logic             underflow;

  sync_fifo_prog #(
    .DSIZE(DSIZE), .ASIZE(ASIZE), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .wfull(wfull),
    .walmost_full(walmost_full), .rinc(rinc), .rdata(rdata), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .count(count), .clr_err(clr_err),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [7:0] mq[$];
  logic [7:0] m_rdata = '0;
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy is the queue length, head is mq[0].
  always @(posedge clk) begin
    bit full, empty;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    if (rst) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_rdata = '0;
    end else begin
      m_ovf = (m_ovf && !clr_err) || (winc && full);
      m_udf = (m_udf && !clr_err) || (rinc && empty);
      if (rinc && !empty) m_rdata = mq.pop_front();
      if (winc && !full)  mq.push_back(wdata);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", count, mq.size());
      chk("wfull", wfull, mq.size() == DEPTH);
      chk("rempty", rempty, mq.size() == 0);
      chk("walmost_full", walmost_full, mq.size() >= AF);
      chk("ralmost_empty", ralmost_empty, mq.size() <= AE);
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_udf);
`ifdef SYNC_FIFO_PROG_FWFT_EN
      if (mq.size() != 0) chk("rdata", rdata, mq[0]);
`else
      chk("rdata", rdata, m_rdata);
`endif
    end
  end

  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c, input bit rs);
    @(negedge clk);
    winc = w; wdata = d; rinc = r; clr_err = c; rst = rs;
    @(posedge clk);
    #1;
    winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wn, rn, cyc, wbias, rbias;
    logic [7:0] d;
    winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; rst = 1'b0; wdata = '0;

    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 1, 0, 1);
    chk_en = 1'b1;
    chk("rst_count", count, 0);
    chk("rst_rempty", rempty, 1);
    chk("rst_ralmost_empty", ralmost_empty, 1);
    chk("rst_wfull", wfull, 0);
    chk("rst_rdata", rdata, 8'h00);

    for (int i = 1; i <= 16; i++) begin
      step(1, 8'(i), 0, 0, 0);
      if (i == 13) chk("af_at_13", walmost_full, 0);
      if (i == 14) chk("af_at_14", walmost_full, 1);
      if (i == 15) chk("wfull_at_15", wfull, 0);
    end
    chk("fill_count", count, 16);
    chk("fill_wfull", wfull, 1);
    chk("fill_rempty", rempty, 0);

    for (int i = 1; i <= 16; i++) begin
      step(0, 8'h00, 1, 0, 0);
`ifdef SYNC_FIFO_PROG_FWFT_EN
      if (i < 16) chk("drain_rdata", rdata, 8'(i + 1));
`else
      chk("drain_rdata", rdata, 8'(i));
`endif
      if (i == 13) chk("ae_at_3", ralmost_empty, 0);
      if (i == 14) chk("ae_at_2", ralmost_empty, 1);
    end
    chk("drain_count", count, 0);
    chk("drain_rempty", rempty, 1);

    for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, 0, 0);
    step(1, 8'h11, 1, 0, 0);
    chk("ovf_count", count, 15);
    chk("ovf_flag", overflow, 1);
`ifndef SYNC_FIFO_PROG_FWFT_EN
    chk("ovf_head", rdata, 8'h01);
`endif
    step(0, 8'h00, 0, 0, 0);
    chk("ovf_sticky", overflow, 1);
    step(0, 8'h00, 0, 1, 0);
    chk("ovf_clear", overflow, 0);
    for (int i = 0; i < 15; i++) step(0, 8'h00, 1, 0, 0);
`ifndef SYNC_FIFO_PROG_FWFT_EN
    chk("ovf_last_word", rdata, 8'h10);
`endif
    chk("ovf_drained", count, 0);

    step(1, 8'hA5, 1, 0, 0);
    chk("udf_count", count, 1);
    chk("udf_flag", underflow, 1);
`ifdef SYNC_FIFO_PROG_FWFT_EN
    chk("udf_fwft_head", rdata, 8'hA5);
`endif
    step(0, 8'h00, 1, 0, 0);
`ifndef SYNC_FIFO_PROG_FWFT_EN
    chk("udf_read", rdata, 8'hA5);
`endif
    step(0, 8'h00, 0, 1, 0);
    chk("udf_clear", underflow, 0);

    wn = 0; rn = 0; cyc = 0;
    while ((wn < 40 || rn < 40) && cyc < 400) begin
      bit w, r;
      w = (wn < 40) && ($urandom_range(0, 2) != 0);
      r = (rn < 40) && ($urandom_range(0, 1) != 0);
      @(negedge clk);
      if (w && !wfull) wn++;
      if (r && !rempty) rn++;
      step(w, 8'(8'h40 + wn), r, 0, 0);
      cyc++;
    end
    chk("interleave_done", (wn == 40 && rn == 40), 1);

    for (int i = 0; i < 5; i++) step(1, 8'(8'h70 + i), 0, 0, 0);
    step(1, 8'hEE, 1, 0, 1);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_rempty", rempty, 1);
    chk("mid_rst_af", walmost_full, 0);
    step(1, 8'h3C, 0, 0, 0);
`ifdef SYNC_FIFO_PROG_FWFT_EN
    chk("post_rst_fwft", rdata, 8'h3C);
`endif
    step(0, 8'h00, 1, 0, 0);
`ifndef SYNC_FIFO_PROG_FWFT_EN
    chk("post_rst_read", rdata, 8'h3C);
`endif

    wbias = 50; rbias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        wbias = $urandom_range(10, 90);
        rbias = $urandom_range(10, 90);
      end
      d = 8'($urandom);
      step($urandom_range(0, 99) < wbias, d, $urandom_range(0, 99) < rbias,
           $urandom_range(0, 19) == 0, $urandom_range(0, 249) == 0);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
